// File: rtl/panel_pkg.sv
// panel_pkg: shared types, geometry and defaults for the HUB75-style
// panel scan controller.
// Build option: GHOST_BLANK_EN adds a 2-cycle BLANK state between DISPLAY
// and NEXT (anti-ghosting). Undefined by default.
package panel_pkg;

  // Panel geometry driven by the external column/row counters
  localparam int PANEL_COLS = 64;
  localparam int PANEL_ROWS = 32;

  // Default BCM configuration
  localparam int DEF_PLANES  = 4;
  localparam int DEF_BASE_OE = 8;

  // Scan sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SHIFT_LO = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_LATCH    = 3'd3,
    ST_DISPLAY  = 3'd4,
    ST_NEXT     = 3'd5
`ifdef GHOST_BLANK_EN
    ,
    ST_BLANK    = 3'd6
`endif
  } scan_state_e;

  // Number of bits needed to hold any count 0..max_val inclusive
  function automatic int timer_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    if (w < 1) begin
      w = 1;
    end else begin
      w = w;
    end
    return w;
  endfunction

endpackage

// File: rtl/oe_timer.sv
// oe_timer: loadable down-counter timing the DISPLAY (and, with
// GHOST_BLANK_EN, BLANK) intervals. Loading value N-1 makes done rise
// after N cycles of the loaded interval; done stays high while idle at 0.
module oe_timer
  import panel_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             done
);

  localparam logic [WIDTH-1:0] T_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] T_ONE  = WIDTH'(1'b1);

  logic [WIDTH-1:0] count_r;
  logic [WIDTH-1:0] count_s;
  logic             done_r;

  // Next count: load wins, otherwise count down and stop at zero
  always_comb begin
    count_s = count_r;
    if (load) begin
      count_s = value;
    end else if (count_r != T_ZERO) begin
      count_s = count_r - T_ONE;
    end else begin
      count_s = count_r;
    end
  end

  // Count register with registered terminal flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= T_ZERO;
      done_r  <= 1'b1;
    end else begin
      count_r <= count_s;
      done_r  <= (count_s == T_ZERO);
    end
  end

  assign done = done_r;

endmodule

// File: rtl/panel_scan_ctrl.sv
// panel_scan_ctrl: row/bit-plane scan sequencer for a 64x32 LED panel
// using binary code modulation. Per plane: 64 two-cycle column shifts,
// one latch cycle, BASE_OE<<plane display cycles, one NEXT cycle.
// Build option: GHOST_BLANK_EN inserts a 2-cycle blanked BLANK state
// between DISPLAY and NEXT.
// All panel outputs are registered, decoded from the next state so they
// line up with the state register; reset clears them asynchronously.
module panel_scan_ctrl
  import panel_pkg::*;
#(
  parameter int PLANES  = DEF_PLANES,
  parameter int BASE_OE = DEF_BASE_OE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       col_max,
  input  logic       row_max,
  output logic       col_inc,
  output logic       row_inc,
  output logic       panel_clk,
  output logic       panel_lat,
  output logic       panel_oe_n,
  output logic [2:0] bit_plane,
  output logic       frame_done
);

  // Longest display interval is the top plane; the timer holds it minus 1
  localparam int              OE_MAX     = BASE_OE << (PLANES - 1);
  localparam int              TW         = timer_width(OE_MAX);
  localparam logic [2:0]      LAST_PLANE = 3'(PLANES - 1);
  localparam logic [TW-1:0]   T_ONE      = TW'(1'b1);
  localparam logic [TW-1:0]   T_BASE     = TW'(BASE_OE);

  scan_state_e state_r;
  scan_state_e state_s;
  logic [2:0]  plane_r;
  logic [2:0]  plane_s;
  logic        last_plane_s;
  logic        row_inc_s;
  logic        frame_done_s;

  logic          timer_load_s;
  logic [TW-1:0] timer_value_s;
  logic [TW-1:0] oe_len_s;
  logic          timer_done_s;

  logic col_inc_r;
  logic row_inc_r;
  logic panel_clk_r;
  logic panel_lat_r;
  logic panel_oe_n_r;
  logic frame_done_r;

  oe_timer #(
    .WIDTH (TW)
  ) u_oe_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (timer_load_s),
    .value (timer_value_s),
    .done  (timer_done_s)
  );

  // Next-state, timer load and plane bookkeeping
  always_comb begin
    state_s       = state_r;
    timer_load_s  = 1'b0;
    timer_value_s = {TW{1'b0}};
    oe_len_s      = T_BASE << plane_r;
    last_plane_s  = (plane_r == LAST_PLANE);

    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_s = ST_SHIFT_LO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT_LO: begin
        state_s = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        if (col_max) begin
          state_s = ST_LATCH;
        end else begin
          state_s = ST_SHIFT_LO;
        end
      end
      ST_LATCH: begin
        // Arm the timer so done rises on the last display cycle
        state_s       = ST_DISPLAY;
        timer_load_s  = 1'b1;
        timer_value_s = oe_len_s - T_ONE;
      end
      ST_DISPLAY: begin
        if (timer_done_s) begin
`ifdef GHOST_BLANK_EN
          state_s       = ST_BLANK;
          timer_load_s  = 1'b1;
          timer_value_s = T_ONE;
`else
          state_s       = ST_NEXT;
`endif
        end else begin
          state_s = ST_DISPLAY;
        end
      end
`ifdef GHOST_BLANK_EN
      ST_BLANK: begin
        if (timer_done_s) begin
          state_s = ST_NEXT;
        end else begin
          state_s = ST_BLANK;
        end
      end
`endif
      ST_NEXT: begin
        if (enable) begin
          state_s = ST_SHIFT_LO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    // Plane advances as NEXT is left, wrapping after the last plane
    if (state_r == ST_NEXT) begin
      if (last_plane_s) begin
        plane_s = 3'd0;
      end else begin
        plane_s = plane_r + 3'd1;
      end
    end else begin
      plane_s = plane_r;
    end

    // Row advance only in the NEXT of the last plane, where OE is off
    row_inc_s    = (state_s == ST_NEXT) && last_plane_s;
    frame_done_s = row_inc_s && row_max;
  end

  // State and plane registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      plane_r <= 3'd0;
    end else begin
      state_r <= state_s;
      plane_r <= plane_s;
    end
  end

  // Registered panel strobes, decoded from the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_inc_r    <= 1'b0;
      row_inc_r    <= 1'b0;
      panel_clk_r  <= 1'b0;
      panel_lat_r  <= 1'b0;
      panel_oe_n_r <= 1'b1;
      frame_done_r <= 1'b0;
    end else begin
      col_inc_r    <= (state_s == ST_SHIFT_HI);
      row_inc_r    <= row_inc_s;
      panel_clk_r  <= (state_s == ST_SHIFT_HI);
      panel_lat_r  <= (state_s == ST_LATCH);
      panel_oe_n_r <= (state_s != ST_DISPLAY);
      frame_done_r <= frame_done_s;
    end
  end

  assign col_inc    = col_inc_r;
  assign row_inc    = row_inc_r;
  assign panel_clk  = panel_clk_r;
  assign panel_lat  = panel_lat_r;
  assign panel_oe_n = panel_oe_n_r;
  assign bit_plane  = plane_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_panel_scan_ctrl.sv
// tb_panel_scan_ctrl: self-checking bench for panel_scan_ctrl with
// external column/row counters attached. Honors GHOST_BLANK_EN.
module tb_panel_scan_ctrl;
  import panel_pkg::*;

  localparam int PLANES  = 4;
  localparam int BASE_OE = 8;
`ifdef GHOST_BLANK_EN
  localparam int BLANK_CYC = 2;
`else
  localparam int BLANK_CYC = 0;
`endif
  localparam int FRAME_CYC = PANEL_ROWS *
      (PLANES * (2 * PANEL_COLS + 2 + BLANK_CYC) + BASE_OE * ((1 << PLANES) - 1));

  typedef logic [8:0] ovec_t; // {col_inc,row_inc,panel_clk,panel_lat,frame_done,panel_oe_n,bit_plane}
  localparam ovec_t RESET_VEC = 9'b00000_1_000;

  typedef struct {
    logic       en;
    logic [2:0] exp_bp;
    int         exp_oe;
    int         exp_len;
    int         exp_rows;
  } vec_t;

  logic clk = 1'b0;
  logic rst, enable, col_max, row_max;
  logic col_inc, row_inc, panel_clk, panel_lat, panel_oe_n, frame_done;
  logic [2:0] bit_plane;

  int total = 0;
  int bad   = 0;
  int col_cnt, row_cnt;

  ovec_t exp_q[$];
  int m_plane, m_row, mcyc, rows_seen, fd_seen, first_fd, viol;
  bit fd_ok;
  vec_t tbl[5];

  always #5 clk = ~clk;

  panel_scan_ctrl #(.PLANES(PLANES), .BASE_OE(BASE_OE)) dut (
    .clk(clk), .rst(rst), .enable(enable), .col_max(col_max), .row_max(row_max),
    .col_inc(col_inc), .row_inc(row_inc), .panel_clk(panel_clk), .panel_lat(panel_lat),
    .panel_oe_n(panel_oe_n), .bit_plane(bit_plane), .frame_done(frame_done)
  );

  // External column/row counters sharing the controller reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt <= 0;
      row_cnt <= 0;
    end else begin
      if (col_inc) col_cnt <= (col_cnt == PANEL_COLS - 1) ? 0 : col_cnt + 1;
      if (row_inc) row_cnt <= (row_cnt == PANEL_ROWS - 1) ? 0 : row_cnt + 1;
    end
  end
  assign col_max = (col_cnt == PANEL_COLS - 1);
  assign row_max = (row_cnt == PANEL_ROWS - 1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
    end
  endtask

  function automatic ovec_t pack_out();
    return {col_inc, row_inc, panel_clk, panel_lat, frame_done, panel_oe_n, bit_plane};
  endfunction

  function automatic ovec_t mk(input logic ci, input logic ri, input logic pc, input logic pl,
                               input logic fd, input logic oe, input logic [2:0] bp);
    return {ci, ri, pc, pl, fd, oe, bp};
  endfunction

  // Reference timeline of one plane, straight from the scan rules
  task automatic push_plane(input int p, input int r);
    logic last;
    logic [2:0] bp;
    last = (p == PLANES - 1);
    bp = 3'(p);
    for (int c = 0; c < PANEL_COLS; c++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bp));
      exp_q.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, bp));
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, bp));
    for (int k = 0; k < (BASE_OE << p); k++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, bp));
    for (int k = 0; k < BLANK_CYC; k++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, bp));
    exp_q.push_back(mk(1'b0, last, 1'b0, 1'b0, last && (r == PANEL_ROWS - 1), 1'b1, bp));
  endtask

  // Run n cycles comparing every output against the reference timeline
  task automatic model_cycles(input int n, input bit rnd);
    ovec_t got, want;
    for (int i = 0; i < n; i++) begin
      if (rnd) enable = ($urandom_range(0, 7) != 0);
      if (exp_q.size() == 0) begin
        if (enable) begin
          push_plane(m_plane, m_row);
          if (m_plane == PLANES - 1) begin
            m_plane = 0;
            m_row = (m_row + 1) % PANEL_ROWS;
          end else begin
            m_plane = m_plane + 1;
          end
        end else begin
          exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'(m_plane)));
        end
      end
      step();
      mcyc++;
      got = pack_out();
      want = exp_q.pop_front();
      check($sformatf("model_cyc%0d", mcyc), got, want);
      rows_seen += int'(row_inc);
      if ((col_inc && row_inc) || (row_inc && !panel_oe_n)) viol++;
      if (frame_done) begin
        fd_seen++;
        if (first_fd == 0) first_fd = mcyc;
        if (!(row_inc && row_max)) fd_ok = 1'b0;
      end
    end
  endtask

  // Observe one plane from its first SHIFT_LO through NEXT
  task automatic measure_plane(output int len, output int cols, output int clks, output int lats,
                               output int lat_cyc, output int oe_low, output int rows,
                               output logic [2:0] bp, output bit bp_stable);
    int after;
    bit seen_low, fin;
    len = 0; cols = 0; clks = 0; lats = 0; lat_cyc = 0; oe_low = 0; rows = 0;
    bp = 3'd0; bp_stable = 1'b1; after = 0; seen_low = 1'b0; fin = 1'b0;
    while (!fin && len < 2000) begin
      step();
      len++;
      if (len == 1) bp = bit_plane;
      else if (bit_plane !== bp) bp_stable = 1'b0;
      cols += int'(col_inc);
      clks += int'(panel_clk);
      rows += int'(row_inc);
      if (panel_lat) begin
        lats++;
        lat_cyc = len;
      end
      if (!panel_oe_n) begin
        oe_low++;
        seen_low = 1'b1;
      end else if (seen_low) begin
        after++;
      end
      if (seen_low && after == BLANK_CYC + 1) fin = 1'b1;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int len, cols, clks, lats, lat_cyc, oe_low, rows, n, lows;
    logic [2:0] bp;
    bit bp_stable, found;

    tbl[0] = '{en: 1'b1, exp_bp: 3'd0, exp_oe: 8,  exp_len: 138 + BLANK_CYC, exp_rows: 0};
    tbl[1] = '{en: 1'b1, exp_bp: 3'd1, exp_oe: 16, exp_len: 146 + BLANK_CYC, exp_rows: 0};
    tbl[2] = '{en: 1'b1, exp_bp: 3'd2, exp_oe: 32, exp_len: 162 + BLANK_CYC, exp_rows: 0};
    tbl[3] = '{en: 1'b1, exp_bp: 3'd3, exp_oe: 64, exp_len: 194 + BLANK_CYC, exp_rows: 1};
    tbl[4] = '{en: 1'b1, exp_bp: 3'd0, exp_oe: 8,  exp_len: 138 + BLANK_CYC, exp_rows: 0};

    // Reset and idle
    rst = 1'b0;
    enable = 1'b0;
    #2 rst = 1'b1;
    step();
    step();
    check("reset_vec", pack_out(), RESET_VEC);
    rst = 1'b0;
    repeat (3) step();
    check("idle_hold", pack_out(), RESET_VEC);

    // Plane table: first row and the start of the second
    for (int i = 0; i < 5; i++) begin
      enable = tbl[i].en;
      measure_plane(len, cols, clks, lats, lat_cyc, oe_low, rows, bp, bp_stable);
      check($sformatf("p%0d_bit_plane", i), bp, tbl[i].exp_bp);
      check($sformatf("p%0d_bp_stable", i), bp_stable, 1);
      check($sformatf("p%0d_oe_low", i), oe_low, tbl[i].exp_oe);
      check($sformatf("p%0d_length", i), len, tbl[i].exp_len);
      check($sformatf("p%0d_col_inc", i), cols, 64);
      check($sformatf("p%0d_clk_high", i), clks, 64);
      check($sformatf("p%0d_lat_count", i), lats, 1);
      check($sformatf("p%0d_lat_cycle", i), lat_cyc, 129);
      check($sformatf("p%0d_row_inc", i), rows, tbl[i].exp_rows);
    end

    // Drop enable in the middle of plane 1 display
    found = 1'b0;
    n = 0;
    while (!found && n < 400) begin
      step();
      n++;
      if (!panel_oe_n) found = 1'b1;
    end
    check("drop_reach_display", found, 1);
    check("drop_bit_plane", bit_plane, 1);
    oe_low = found ? 1 : 0;
    repeat (4) begin
      step();
      if (!panel_oe_n) oe_low++;
    end
    enable = 1'b0;
    n = 0;
    while (!panel_oe_n && n < 100) begin
      step();
      n++;
      if (!panel_oe_n) oe_low++;
    end
    check("drop_oe_len", oe_low, 16);
    repeat (BLANK_CYC) step();
    check("drop_next_oe_n", panel_oe_n, 1);
    check("drop_next_row_inc", row_inc, 0);
    cols = 0;
    lows = 0;
    repeat (200) begin
      step();
      cols += int'(col_inc);
      if (!panel_oe_n) lows++;
    end
    check("drop_no_col_inc", cols, 0);
    check("drop_oe_off", lows, 0);
    check("drop_idle_bp", bit_plane, 2);

    // Asynchronous reset during SHIFT_HI of column 30
    enable = 1'b1;
    cols = 0;
    n = 0;
    while (cols < 31 && n < 200) begin
      step();
      n++;
      cols += int'(col_inc);
    end
    check("rst_reach_col30", cols, 31);
    check("rst_col_cnt30", col_cnt, 30);
    #2 rst = 1'b1;
    #1;
    check("rst_async_vec", pack_out(), RESET_VEC);
    check("rst_async_cnt", col_cnt, 0);
    step();
    step();
    rst = 1'b0;
    measure_plane(len, cols, clks, lats, lat_cyc, oe_low, rows, bp, bp_stable);
    check("rerun_bit_plane", bp, 0);
    check("rerun_lat_cycle", lat_cyc, 129);
    check("rerun_col_inc", cols, 64);
    check("rerun_oe_low", oe_low, 8);
    check("rerun_length", len, 138 + BLANK_CYC);

    // Full frame then randomized enable, against the reference timeline
    rst = 1'b1;
    enable = 1'b0;
    step();
    rst = 1'b0;
    step();
    exp_q.delete();
    m_plane = 0; m_row = 0; mcyc = 0; rows_seen = 0; fd_seen = 0; first_fd = 0;
    viol = 0; fd_ok = 1'b1;
    enable = 1'b1;
    model_cycles(FRAME_CYC, 1'b0);
    check("frame_row_inc", rows_seen, 32);
    check("frame_done_count", fd_seen, 1);
    check("frame_length", first_fd, FRAME_CYC);
    check("frame_done_on_last_row", fd_ok, 1);
    model_cycles(25000, 1'b1);
    check("strobe_invariants", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/panel_scan_ctrl.md
PANEL_SCAN_CTRL -- requirements
Module: panel_scan_ctrl

Interface
REQ-001 Parameter PLANES, default 4, is the number of BCM bit planes per row (1..8).
REQ-002 Parameter BASE_OE, default 8, is the plane-0 display time in clk cycles (>=1).
REQ-003 Port clk  input  1  is the single system clock, rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port enable  input  1  starts and sustains scanning while high.
REQ-006 Port col_max  input  1  flags the column counter at 63.
REQ-007 Port row_max  input  1  flags the row counter at 31.
REQ-008 Port col_inc  output  1  is the one-cycle column-advance strobe.
REQ-009 Port row_inc  output  1  is the one-cycle row-advance strobe.
REQ-010 Port panel_clk  output  1  is the panel shift clock.
REQ-011 Port panel_lat  output  1  is the panel latch strobe.
REQ-012 Port panel_oe_n  output  1  is the panel output enable, active low.
REQ-013 Port bit_plane  output  3  is the current BCM plane index, used by pixel fetch.
REQ-014 Port frame_done  output  1  is a one-cycle pulse at the end of a full frame.

Function
REQ-015 The FSM states SHALL be IDLE, SHIFT_LO, SHIFT_HI, LATCH, DISPLAY, and NEXT.
- IDLE: all strobes 0, panel_oe_n=1; enable=1 -> SHIFT_LO.
REQ-016 Each column SHALL take 2 cycles.
- SHIFT_LO: panel_clk=0, data setup.
- SHIFT_HI: panel_clk=1, col_inc=1.
- SHIFT_HI with col_max=1 -> LATCH; otherwise -> SHIFT_LO.
REQ-017 LATCH SHALL last exactly 1 cycle: panel_lat=1, panel_oe_n=1, then -> DISPLAY.
REQ-018 DISPLAY SHALL hold panel_oe_n=0 for exactly BASE_OE<<bit_plane cycles, counted by an internal timer, then -> NEXT.
REQ-019 NEXT SHALL last 1 cycle with panel_oe_n=1.
- bit_plane<PLANES-1: bit_plane increments.
- bit_plane==PLANES-1: bit_plane<=0 and row_inc=1.
- If also row_max=1: frame_done=1.
REQ-020 From NEXT, enable=1 -> SHIFT_LO; enable=0 -> IDLE. enable is sampled only in IDLE and NEXT.
REQ-021 col_inc and row_inc SHALL never be asserted in the same cycle; row_inc SHALL occur only while panel_oe_n=1.
REQ-022 The timer width SHALL hold BASE_OE<<(PLANES-1) without overflow; bit_plane wraps modulo PLANES.
REQ-023 Cycles per plane SHALL be 128 + 1 + (BASE_OE<<p) + 1, plus 2 when GHOST_BLANK_EN is defined.

Reset
REQ-024 Asserting rst SHALL immediately force state IDLE, bit_plane=0, timer=0, col_inc=row_inc=panel_clk=panel_lat=frame_done=0, and panel_oe_n=1, including mid-shift or mid-display.
REQ-025 After rst deasserts, the first SHIFT_LO SHALL be entered on the first clk edge with enable=1. The external counters share rst.

Configuration
REQ-026 Macro GHOST_BLANK_EN, when defined, SHALL add a state BLANK of 2 cycles (panel_oe_n=1, all strobes 0) between DISPLAY and NEXT, for anti-ghosting.
- When undefined, DISPLAY goes directly to NEXT and no BLANK state exists.

Structure
REQ-027 Package panel_pkg SHALL hold:
- the scan state enum;
- the constants PANEL_COLS=64 and PANEL_ROWS=32;
- the default PLANES and BASE_OE values.
REQ-028 One sub-module, oe_timer, SHALL implement the loadable down-counter for DISPLAY/BLANK durations, with load, value, and done signals.

Verification
REQ-029 Reset then enable=1, with counters attached: 64 col_inc pulses, 64 panel_clk highs, then panel_lat high for exactly 1 cycle at cycle 129.
REQ-030 Plane 0..3, BASE_OE=8: panel_oe_n low for exactly 8, 16, 32, and 64 cycles respectively; bit_plane reads 0,1,2,3 then 0.
REQ-031 Full frame: 32 row_inc pulses and exactly one frame_done, coincident with the row_inc where row_max=1; frame length = 32*(4*130+120) = 20480 cycles with the macro off.
REQ-032 enable dropped mid-DISPLAY of plane 1: the display completes its 16 cycles, then NEXT, then IDLE; no further col_inc.
REQ-033 rst asserted at column 30 of SHIFT_HI: outputs reach reset values without a clk edge; re-run restarts at column 0, plane 0.
REQ-034 GHOST_BLANK_EN defined: 2 cycles with panel_oe_n=1 between each DISPLAY end and NEXT; row_inc never coincides with panel_oe_n=0.
